// File: rtl/game_pkg.sv
// Shared game definitions: board geometry, key indexing and controller state encodings.
package game_pkg;

    localparam int unsigned NUM_KEYS = 9;
    localparam int unsigned ROWS     = 3;
    localparam int unsigned COLS     = 3;

    // Game controller state encodings, shared with the controller.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        PLAY   = 2'd1,
        FINISH = 2'd2
    } game_state_e;

    // Currently driven matrix column.
    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_e;

    // Flat key index of a matrix position.
    function automatic int unsigned key_idx(input int unsigned row, input int unsigned col);
        return row * COLS + col;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: the stable state flips only after DEB_SCANS consecutive
// disagreeing samples; samples are taken only on the sample strobe.
module key_debounce
    import game_pkg::*;
#(
    parameter int unsigned DEB_SCANS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    input  logic raw,
    output logic stable,
    output logic flip_c
);

    localparam int unsigned CW = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_d;

    // Next counter / stable state; flip_c flags the edge on which stable changes.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable;
        flip_c   = 1'b0;
        if (sample) begin
            if (raw == stable) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEB_SCANS - 1)) begin
                stable_d = raw;
                cnt_d    = '0;
                flip_c   = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            stable <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            stable <= stable_d;
        end
    end

endmodule

// File: rtl/box_scanner.sv
// 3x3 active-low key matrix scanner with per-key debounce, producing the level-held
// box vector for the game controller. Optional macro BOX_ONEHOT_EN reports only the
// lowest-indexed pressed key.
module box_scanner
    import game_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned DEB_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [ROWS-1:0]     row_n,
    output logic [COLS-1:0]     col_n,
    output logic [NUM_KEYS-1:0] box,
    output logic                box_change,
    output logic                frame_done
);

    localparam int unsigned DW = $clog2(SCAN_DIV);

    logic [ROWS-1:0]     row_meta;
    logic [ROWS-1:0]     row_sync;

    logic [DW-1:0]       div_q;
    logic [DW-1:0]       div_d;
    col_e                col_q;
    col_e                col_d;
    logic [COLS-1:0]     col_n_d;
    logic                frame_done_d;
    logic                sample_c;
    logic [COLS-1:0]     col_sel_c;

    logic [NUM_KEYS-1:0] deb_vec;
    logic [NUM_KEYS-1:0] flip_vec;
    logic [NUM_KEYS-1:0] deb_next_c;
    logic [NUM_KEYS-1:0] box_d;

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    // Column FSM and divider state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= COL0;
            div_q      <= '0;
            col_n      <= 3'b110;
            frame_done <= 1'b0;
        end else begin
            col_q      <= col_d;
            div_q      <= div_d;
            col_n      <= col_n_d;
            frame_done <= frame_done_d;
        end
    end

    // Divider, column advance and sample strobe; disabled scanning parks at column 0.
    always_comb begin
        div_d        = div_q;
        col_d        = col_q;
        sample_c     = 1'b0;
        frame_done_d = 1'b0;
        if (!en) begin
            div_d = '0;
            col_d = COL0;
        end else if (div_q == DW'(SCAN_DIV - 1)) begin
            sample_c     = 1'b1;
            div_d        = '0;
            frame_done_d = (col_q == COL2);
            case (col_q)
                COL0:    col_d = COL1;
                COL1:    col_d = COL2;
                default: col_d = COL0;
            endcase
        end else begin
            div_d = div_q + DW'(1);
        end
        col_n_d = en ? ~(3'b001 << col_d) : 3'b111;
    end

    // One-hot select of the column currently being sampled.
    assign col_sel_c = 3'b001 << col_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int unsigned K = key_idx(r, c);
            key_debounce #(
                .DEB_SCANS (DEB_SCANS)
            ) u_deb (
                .clk    (clk),
                .rst_n  (rst_n),
                .sample (sample_c & col_sel_c[c]),
                .raw    (~row_sync[r]),
                .stable (deb_vec[K]),
                .flip_c (flip_vec[K])
            );
        end
    end

    // Debounced vector as it will be after this edge, so box lands with the flip.
    assign deb_next_c = deb_vec ^ flip_vec;

`ifdef BOX_ONEHOT_EN
    // Report only the lowest-indexed pressed key.
    assign box_d = deb_next_c & (~deb_next_c + NUM_KEYS'(1));
`else
    assign box_d = deb_next_c;
`endif

    // Output box register with its single-cycle change strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box        <= '0;
            box_change <= 1'b0;
        end else begin
            box        <= box_d;
            box_change <= (box_d != box);
        end
    end

endmodule

// File: tb/tb_box_scanner.sv
// Self-checking bench for box_scanner (SCAN_DIV=4, DEB_SCANS=3, frame = 12 clk).
module tb_box_scanner;

    localparam int unsigned SD   = 4;
    localparam int unsigned DEB  = 3;
    localparam int unsigned FRM  = 12;
`ifdef BOX_ONEHOT_EN
    localparam bit ONEHOT = 1'b1;
`else
    localparam bit ONEHOT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] row_n;
    logic [2:0] col_n;
    logic [8:0] box;
    logic       box_change;
    logic       frame_done;

    logic [8:0] pressed;

    box_scanner #(.SCAN_DIV(SD), .DEB_SCANS(DEB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .row_n      (row_n),
        .col_n      (col_n),
        .box        (box),
        .box_change (box_change),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 3'b111;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    int total = 0;
    int bad   = 0;
    int chg_seen;
    int fd_seen;

    // Reference model state (cycle position in the frame, per-key debounce).
    int         m_phase;
    logic [8:0] m_deb;
    int         m_cnt [9];
    logic [8:0] m_box;
    logic       m_chg;
    logic       m_fd;
    logic [2:0] m_coln;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_deb   = '0;
        m_box   = '0;
        m_chg   = 1'b0;
        m_fd    = 1'b0;
        m_coln  = 3'b110;
        for (int k = 0; k < 9; k++) m_cnt[k] = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_edge();
        logic [8:0] vis;
        logic [2:0] one;
        int         c;
        int         k;
        one   = 3'b001;
        m_chg = 1'b0;
        m_fd  = 1'b0;
        if (!en) begin
            m_phase = 0;
            m_coln  = 3'b111;
        end else begin
            if (m_phase % SD == SD - 1) begin
                c = m_phase / SD;
                for (int r = 0; r < 3; r++) begin
                    k = r * 3 + c;
                    if (pressed[k] == m_deb[k]) m_cnt[k] = 0;
                    else if (m_cnt[k] == DEB - 1) begin
                        m_deb[k] = pressed[k];
                        m_cnt[k] = 0;
                    end else m_cnt[k]++;
                end
                m_fd = (c == 2);
                vis  = ONEHOT ? (m_deb & (~m_deb + 9'd1)) : m_deb;
                m_chg = (vis != m_box);
                m_box = vis;
            end
            m_phase = (m_phase + 1) % FRM;
            m_coln  = ~(one << (m_phase / SD));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("col_n", 9'(col_n), 9'(m_coln));
        chk("box", box, m_box);
        chk("box_change", 9'(box_change), 9'(m_chg));
        chk("frame_done", 9'(frame_done), 9'(m_fd));
        if (box_change) chg_seen++;
        if (frame_done) fd_seen++;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n * FRM; i++) step();
    endtask

    typedef struct {
        logic [8:0]  press;
        int          frames;
        logic [8:0]  exp_box;
        int          exp_chg;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{9'h010, 3, 9'h010, 1};
        tbl[1] = '{9'h000, 3, 9'h000, 1};
        tbl[2] = '{9'h001, 2, 9'h000, 0};
        tbl[3] = '{9'h000, 1, 9'h000, 0};
        tbl[4] = '{9'h001, 3, 9'h001, 1};
        tbl[5] = '{9'h000, 3, 9'h000, 1};
        tbl[6] = '{9'h104, 3, (ONEHOT ? 9'h004 : 9'h104), 1};

        rst_n   = 1'b1;
        en      = 1'b0;
        pressed = '0;
        chg_seen = 0;
        fd_seen  = 0;
        #2 rst_n = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col_n", 9'(col_n), 9'h006);
        chk("rst_box", box, 9'h000);
        chk("rst_box_change", 9'(box_change), 9'h000);
        chk("rst_frame_done", 9'(frame_done), 9'h000);
        rst_n = 1'b1;
        model_reset();
        repeat (3) step();
        chk("idle_col_n", 9'(col_n), 9'h007);

        // Idle scanning: frame_done every 12 clk, box stays clear
        en = 1'b1;
        fd_seen = 0;
        chg_seen = 0;
        run_frames(3);
        chk("idle_frames", 9'(fd_seen), 9'd3);
        chk("idle_changes", 9'(chg_seen), 9'd0);

        // Table of press patterns, each applied from a frame boundary
        for (int i = 0; i < 7; i++) begin
            pressed  = tbl[i].press;
            chg_seen = 0;
            fd_seen  = 0;
            run_frames(tbl[i].frames);
            chk("tbl_box", box, tbl[i].exp_box);
            chk("tbl_changes", 9'(chg_seen), 9'(tbl[i].exp_chg));
            chk("tbl_frames", 9'(fd_seen), 9'(tbl[i].frames));
        end
        pressed = '0;
        run_frames(3);
        chk("release_all", box, 9'h000);

        // Enable dropped mid column-1 phase with key 4 held
        pressed = 9'h010;
        run_frames(3);
        chk("hold_pre", box, 9'h010);
        repeat (5) step();
        en = 1'b0;
        chg_seen = 0;
        fd_seen  = 0;
        repeat (6) step();
        chk("en0_col_n", 9'(col_n), 9'h007);
        chk("en0_box", box, 9'h010);
        chk("en0_strobes", 9'(chg_seen + fd_seen), 9'd0);
        en = 1'b1;
        run_frames(1);

        // Reset mid-debounce: counter progress must be discarded
        pressed = '0;
        run_frames(3);
        chk("release4", box, 9'h000);
        pressed = 9'h010;
        run_frames(2);
        repeat (2) step();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_box", box, 9'h000);
        chk("mid_rst_col_n", 9'(col_n), 9'h006);
        chk("mid_rst_change", 9'(box_change), 9'h000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run_frames(2);
        chk("post_rst_2f", box, 9'h000);
        run_frames(1);
        chk("post_rst_3f", box, 9'h010);

        // Randomised press patterns against the model
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 2) == 0)
                pressed = 9'($urandom) & 9'($urandom);
            run_frames(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
